fetch_stage: RTL

Instruction-fetch stage of the single-issue RISC-V core. Owns the program counter, drives the word address into the combinational instruction memory, and captures the returned instruction into the IF/ID pipeline register for decode. Handles decode-side stalls and execute-side branch/jump redirects, inserting a NOP bubble on redirect.

---
 rtl/fetch_stage.sv | 88 ++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and fills the IF/ID register.
// Optional macro FETCH_MISALIGN_CHECK_EN traps misaligned redirect targets to TRAP_VEC.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0010
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_if_id_valid,
  output logic [31:0] o_if_id_instr,
  output logic [31:0] o_if_id_pc,
  output logic [31:0] o_if_id_pc4,
  output logic        o_misalign
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // PC is kept as a word index so the byte address is always 4-byte aligned.
  logic [29:0] r_pc_w;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_pc4;
  logic        r_misalign;

  logic [29:0] w_pc_next_w;
  logic [29:0] w_target_w;
  logic        w_mis_req;

  assign w_pc_next_w = r_pc_w + 30'd1;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign w_mis_req  = |i_redirect_pc[1:0];
  assign w_target_w = w_mis_req ? TRAP_VEC[31:2] : i_redirect_pc[31:2];
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{i_redirect_pc[1:0], TRAP_VEC};
  assign w_mis_req    = 1'b0;
  assign w_target_w   = i_redirect_pc[31:2];
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc_w     <= RESET_PC[31:2];
      r_valid    <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_if_pc    <= 32'h0000_0000;
      r_if_pc4   <= 32'h0000_0000;
      r_misalign <= 1'b0;
    end else if (i_redirect) begin
      // Redirect beats stall; the wrong-path fetch becomes a bubble.
      r_pc_w     <= w_target_w;
      r_valid    <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_if_pc    <= 32'h0000_0000;
      r_if_pc4   <= 32'h0000_0000;
      r_misalign <= w_mis_req;
    end else if (i_stall) begin
      r_misalign <= 1'b0;
    end else begin
      r_pc_w     <= w_pc_next_w;
      r_valid    <= 1'b1;
      r_instr    <= i_imem_rdata;
      r_if_pc    <= {r_pc_w, 2'b00};
      r_if_pc4   <= {w_pc_next_w, 2'b00};
      r_misalign <= 1'b0;
    end
  end

  assign o_imem_addr   = {r_pc_w, 2'b00};
  assign o_if_id_valid = r_valid;
  assign o_if_id_instr = r_instr;
  assign o_if_id_pc    = r_if_pc;
  assign o_if_id_pc4   = r_if_pc4;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign o_misalign    = r_misalign;
`else
  assign o_misalign    = 1'b0;
  logic w_unused_mis;
  assign w_unused_mis  = r_misalign;
`endif

endmodule
